// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between NUM_REQ requesters, with burst lock.
// Define SRAM_PORT_ARBITER_STAT_EN to add per-requester saturating access counters (stat_cnt_o, stat_clr_i).
module sram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LOCK   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0]                req_wen_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_bm_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              ram_en_o,
  output logic                              ram_wen_o,
  output logic [DATA_WIDTH/8-1:0]           ram_bm_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic [DATA_WIDTH-1:0]             ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]             ram_rdata_i,
`ifdef SRAM_PORT_ARBITER_STAT_EN
  input  logic                              stat_clr_i,
  output logic [NUM_REQ*16-1:0]             stat_cnt_o,
`endif
  output logic [$clog2(NUM_REQ)-1:0]        grant_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BM_W = DATA_WIDTH / 8;

  localparam logic [ID_W-1:0] ID_MAX    = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [7:0]      LOCK_MAX  = 8'(MAX_LOCK);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [7:0]      lock_cnt;
  logic [7:0]      lock_nxt;
  logic [ID_W-1:0] winner;
  logic            grant;
  logic            rsp_pend;
  logic [ID_W-1:0] rsp_tag;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (p == ID_MAX) ? '0 : p + 1'b1;
  endfunction

  // While locked only the owner may win; its idle cycles leave the bank idle.
  always_comb begin
    logic [ID_W:0] idx;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    winner = '0;
    grant  = 1'b0;
    idx    = '0;
    if (state == ST_LOCKED) begin
      winner = owner;
      grant  = req_valid_i[owner];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
        if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
        if (!grant && req_valid_i[idx[ID_W-1:0]]) begin
          grant  = 1'b1;
          winner = idx[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    ram_en_o    = 1'b0;
    ram_wen_o   = 1'b0;
    ram_bm_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    grant_id_o  = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
      ram_en_o    = 1'b1;
      ram_wen_o   = req_wen_i[winner];
      ram_bm_o    = req_bm_i[int'(winner)*BM_W +: BM_W];
      ram_addr_o  = req_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata_o = req_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      grant_id_o  = winner;
    end
  end

  assign lock_nxt = lock_cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state    <= ST_ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (grant) begin
      if (state == ST_ARB) begin
        // A cap of one grant means a lock request would be released on entry.
        if (req_lock_i[winner] && (LOCK_MAX != 8'd1)) begin
          state    <= ST_LOCKED;
          owner    <= winner;
          lock_cnt <= 8'd1;
        end else begin
          rr_ptr <= next_ptr(winner);
        end
      end else begin
        if (!req_lock_i[owner] || (lock_nxt == LOCK_MAX)) begin
          state    <= ST_ARB;
          rr_ptr   <= next_ptr(owner);
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_nxt;
        end
      end
    end
  end

  // Read data arrives one cycle after the grant; the tag follows it in order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_pend <= 1'b0;
      rsp_tag  <= '0;
    end else begin
      rsp_pend <= grant && !ram_wen_o;
      if (grant) rsp_tag <= winner;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rsp_pend) begin
      rsp_valid_o[rsp_tag] = 1'b1;
      rsp_rdata_o          = ram_rdata_i;
    end
  end

`ifdef SRAM_PORT_ARBITER_STAT_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr_i) begin
          stat_cnt[i] <= '0;
        end else if (req_ready_o[i] && (stat_cnt[i] != 16'hFFFF)) begin
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt_o[i*16 +: 16] = stat_cnt[i];
  end
`endif

endmodule
